// File: rtl/sdram_pkg.sv
// sdram_pkg: shared encodings and types for the SDR SDRAM device responder.
// Command encodings are {nRAS, nCAS, nWE} as sampled with nCS low and CKE high.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_LOAD_MODE  = 3'b000,
    CMD_REFRESH    = 3'b001,
    CMD_PRECHARGE  = 3'b010,
    CMD_ACTIVE     = 3'b011,
    CMD_WRITE      = 3'b100,
    CMD_READ       = 3'b101,
    CMD_BURST_TERM = 3'b110,
    CMD_NOP        = 3'b111
  } sdram_cmd_e;

  // Mode register field offsets within A[]
  localparam int unsigned MODE_BL_LSB = 0;
  localparam int unsigned MODE_BL_W   = 3;
  localparam int unsigned MODE_CL_LSB = 4;
  localparam int unsigned MODE_CL_W   = 3;
  localparam int unsigned A10_BIT     = 10;

  // Address pin width; also the widest row the bank table can hold
  localparam int unsigned ROW_MAX = 11;
  // ACTIVE->READ/WRITE distance counter width (T_RCD up to 15)
  localparam int unsigned TRCD_W  = 4;

  // Last protocol error cause (0 = none)
  typedef enum logic [3:0] {
    ERR_NONE        = 4'd0,
    ERR_MODE_OPEN   = 4'd1,  // LOAD_MODE with a bank open
    ERR_CL          = 4'd2,  // unsupported CAS latency
    ERR_BL          = 4'd3,  // burst length other than 1
    ERR_ACT_OPEN    = 4'd4,  // ACTIVE on an already open bank
    ERR_NO_MODE     = 4'd5,  // READ/WRITE before LOAD_MODE
    ERR_BANK_CLOSED = 4'd6,  // READ/WRITE to a closed bank
    ERR_REF_OPEN    = 4'd7,  // AUTO_REFRESH with a bank open
    ERR_BST         = 4'd8,  // BURST_TERMINATE unsupported
    ERR_WR_RD       = 4'd9,  // WRITE while read data pending
    ERR_TRCD        = 4'd10  // READ/WRITE too soon after ACTIVE
  } sdram_err_e;

  typedef struct packed {
    logic               open;
    logic [ROW_MAX-1:0] row;
  } bank_t;

  // Zero every byte whose mask bit is set
  function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      r[8*i +: 8] = m[i] ? 8'h00 : d[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// sdram_resp_mem: single-port 2^AW x 32 backing RAM with byte write enables
// and a registered read port that only updates when a read is requested.
module sdram_resp_mem #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  // Byte-masked write and 1-clk registered read; rdata holds between reads
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: memory-chip end of the 32-bit SDR SDRAM pin interface.
// Decodes commands, tracks open rows, honours CAS latency and byte masks and
// serves accesses from on-chip RAM.
// Define SDRAM_RESP_CHECK_EN to add the ACTIVE->READ/WRITE (T_RCD) check and
// the err_code output.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int unsigned MEM_AW      = 14,
  parameter int unsigned ROW_BITS    = 11,
  parameter int unsigned COL_BITS    = 8,
  parameter int unsigned WDATA_EARLY = 0,
  parameter int unsigned T_RCD       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sdram_cke,
  input  logic        sdram_ncs,
  input  logic        sdram_nras,
  input  logic        sdram_ncas,
  input  logic        sdram_nwe,
  input  logic [1:0]  sdram_ba,
  input  logic [10:0] sdram_a,
  input  logic [3:0]  sdram_dqm,
  input  logic [31:0] sdram_dq_i,
  output logic [31:0] sdram_dq_o,
  output logic        sdram_dq_oe,
  output logic [15:0] refresh_cnt,
  output logic        cmd_err
`ifdef SDRAM_RESP_CHECK_EN
  ,
  output logic [3:0]  err_code
`endif
);

  sdram_cmd_e  cmd;
  bank_t [3:0] banks_q, banks_d;
  logic [2:0]  cas_lat_q, cas_lat_d;
  logic        mode_set_q, mode_set_d;
  // Read pipe: p0 = RAM read in flight (mask only, data arrives on mem_rdata),
  // p1 = extra stage for CL3 holding masked data, then the dq output register.
  logic        p0_valid_q, p0_valid_d;
  logic [3:0]  p0_mask_q, p0_mask_d;
  logic        p1_valid_q, p1_valid_d;
  logic [31:0] p1_data_q, p1_data_d;
  logic [31:0] dq_o_d;
  logic        dq_oe_d;
  logic [15:0] refresh_d;
  sdram_err_e  err_q, err_d;
  logic [31:0] dq_prev_q;
  logic        any_open, rd_pending;
  logic [2:0]  cl_field;
  logic [MEM_AW-1:0] mem_addr;
  logic        mem_we, mem_re;
  logic [31:0] mem_wdata, mem_rdata;

`ifdef SDRAM_RESP_CHECK_EN
  logic [3:0][TRCD_W-1:0] trcd_q, trcd_d;
`else
  localparam int unsigned unused_t_rcd = T_RCD;
`endif

  assign cmd = (!sdram_ncs && sdram_cke) ? sdram_cmd_e'({sdram_nras, sdram_ncas, sdram_nwe})
                                         : CMD_NOP;
  assign any_open   = banks_q[0].open | banks_q[1].open | banks_q[2].open | banks_q[3].open;
  assign rd_pending = p0_valid_q | p1_valid_q | sdram_dq_oe;
  assign cl_field   = sdram_a[MODE_CL_LSB +: MODE_CL_W];
  // {bank,row,col} folded onto the RAM address; upper bits alias
  assign mem_addr   = MEM_AW'({sdram_ba, banks_q[sdram_ba].row[ROW_BITS-1:0],
                               sdram_a[COL_BITS-1:0]});
  assign mem_wdata  = (WDATA_EARLY != 0) ? dq_prev_q : sdram_dq_i;
  assign cmd_err    = (err_q != ERR_NONE);
`ifdef SDRAM_RESP_CHECK_EN
  assign err_code   = err_q;
`endif

  sdram_resp_mem #(.AW(MEM_AW)) u_mem (
    .clk   (clk),
    .addr  (mem_addr),
    .we    (mem_we),
    .be    (~sdram_dqm),
    .wdata (mem_wdata),
    .re    (mem_re),
    .rdata (mem_rdata)
  );

  // Next-state: read pipe advance, command execution, error/refresh tracking
  always_comb begin
    banks_d    = banks_q;
    cas_lat_d  = cas_lat_q;
    mode_set_d = mode_set_q;
    p0_valid_d = p0_valid_q;
    p0_mask_d  = p0_mask_q;
    p1_valid_d = p1_valid_q;
    p1_data_d  = p1_data_q;
    dq_o_d     = sdram_dq_o;
    dq_oe_d    = sdram_dq_oe;
    refresh_d  = refresh_cnt;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
`ifdef SDRAM_RESP_CHECK_EN
    for (int unsigned i = 0; i < 4; i++) begin
      trcd_d[i] = (trcd_q[i] < TRCD_W'(T_RCD)) ? trcd_q[i] + 1'b1 : trcd_q[i];
    end
`endif

    // Pipe and outputs freeze while CKE is low
    if (sdram_cke) begin
      p0_valid_d = 1'b0;
      p1_valid_d = p0_valid_q && (cas_lat_q == 3'd3);
      p1_data_d  = mask_bytes(mem_rdata, p0_mask_q);
      if (cas_lat_q == 3'd3) begin
        dq_oe_d = p1_valid_q;
        dq_o_d  = p1_valid_q ? p1_data_q : '0;
      end else begin
        dq_oe_d = p0_valid_q;
        dq_o_d  = p0_valid_q ? mask_bytes(mem_rdata, p0_mask_q) : '0;
      end
    end

    case (cmd)
      CMD_LOAD_MODE: begin
        if (any_open) begin
          err_d = ERR_MODE_OPEN;
        end else begin
          mode_set_d = 1'b1;
          if (sdram_a[MODE_BL_LSB +: MODE_BL_W] != '0) err_d = ERR_BL;
          if (cl_field == 3'd2 || cl_field == 3'd3) cas_lat_d = cl_field;
          else                                      err_d     = ERR_CL;
        end
      end
      CMD_ACTIVE: begin
        if (banks_q[sdram_ba].open) err_d = ERR_ACT_OPEN;
        banks_d[sdram_ba].open = 1'b1;
        banks_d[sdram_ba].row  = sdram_a;
`ifdef SDRAM_RESP_CHECK_EN
        trcd_d[sdram_ba] = TRCD_W'(1);
`endif
      end
      CMD_READ, CMD_WRITE: begin
        if (!mode_set_q) begin
          err_d = ERR_NO_MODE;
        end else if (!banks_q[sdram_ba].open) begin
          err_d = ERR_BANK_CLOSED;
        end else begin
`ifdef SDRAM_RESP_CHECK_EN
          if (trcd_q[sdram_ba] < TRCD_W'(T_RCD)) err_d = ERR_TRCD;
`endif
          if (cmd == CMD_READ) begin
            mem_re     = 1'b1;
            p0_valid_d = 1'b1;
            p0_mask_d  = sdram_dqm;
          end else begin
            mem_we = 1'b1;
            if (rd_pending) err_d = ERR_WR_RD;
          end
          if (sdram_a[A10_BIT]) banks_d[sdram_ba].open = 1'b0;
        end
      end
      CMD_PRECHARGE: begin
        if (sdram_a[A10_BIT]) begin
          for (int unsigned i = 0; i < 4; i++) banks_d[i].open = 1'b0;
        end else begin
          banks_d[sdram_ba].open = 1'b0;
        end
      end
      CMD_REFRESH: begin
        if (any_open)                    err_d     = ERR_REF_OPEN;
        else if (refresh_cnt != 16'hFFFF) refresh_d = refresh_cnt + 16'd1;
      end
      CMD_BURST_TERM: err_d = ERR_BST;
      default: ;
    endcase
  end

  // State registers; RAM contents are not touched by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      banks_q     <= '0;
      cas_lat_q   <= 3'd2;
      mode_set_q  <= 1'b0;
      p0_valid_q  <= 1'b0;
      p0_mask_q   <= '0;
      p1_valid_q  <= 1'b0;
      p1_data_q   <= '0;
      sdram_dq_o  <= '0;
      sdram_dq_oe <= 1'b0;
      refresh_cnt <= '0;
      err_q       <= ERR_NONE;
    end else begin
      banks_q     <= banks_d;
      cas_lat_q   <= cas_lat_d;
      mode_set_q  <= mode_set_d;
      p0_valid_q  <= p0_valid_d;
      p0_mask_q   <= p0_mask_d;
      p1_valid_q  <= p1_valid_d;
      p1_data_q   <= p1_data_d;
      sdram_dq_o  <= dq_o_d;
      sdram_dq_oe <= dq_oe_d;
      refresh_cnt <= refresh_d;
      err_q       <= err_d;
    end
  end

  // DQ as seen one clock earlier, for controllers that lead write data
  always_ff @(posedge clk) begin
    dq_prev_q <= sdram_dq_i;
  end

`ifdef SDRAM_RESP_CHECK_EN
  // Per-bank clocks-since-ACTIVE, saturating at T_RCD
  always_ff @(posedge clk) begin
    if (reset) trcd_q <= '0;
    else       trcd_q <= trcd_d;
  end
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed + randomized scoreboard bench for sdram_responder.
module tb_sdram_responder;
  import sdram_pkg::*;

  localparam int MEM_AW = 14;
  localparam int T_RCD  = 3;

  logic        clk = 1'b0;
  logic        reset, cke, ncs, nras, ncas, nwe;
  logic [1:0]  ba;
  logic [10:0] a;
  logic [3:0]  dqm;
  logic [31:0] dq_i, dq_o;
  logic        dq_oe, cmd_err;
  logic [15:0] refresh_cnt;
`ifdef SDRAM_RESP_CHECK_EN
  logic [3:0]  err_code;
`endif

  sdram_responder #(.MEM_AW(MEM_AW), .T_RCD(T_RCD)) dut (
    .clk(clk), .reset(reset), .sdram_cke(cke), .sdram_ncs(ncs),
    .sdram_nras(nras), .sdram_ncas(ncas), .sdram_nwe(nwe),
    .sdram_ba(ba), .sdram_a(a), .sdram_dqm(dqm), .sdram_dq_i(dq_i),
    .sdram_dq_o(dq_o), .sdram_dq_oe(dq_oe), .refresh_cnt(refresh_cnt),
    .cmd_err(cmd_err)
`ifdef SDRAM_RESP_CHECK_EN
    , .err_code(err_code)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct { int exp_edge; logic [31:0] data; } rd_exp_t;
  rd_exp_t exp_q[$];

  // Reference model state
  bit          m_mode, m_err;
  int          m_cl, m_ref, m_last_rd;
  bit          m_open [4];
  int          m_row  [4];
  int          m_act  [4];
  logic [31:0] m_mem  [int];

  function automatic int fold(input int b, input int row, input int col);
    return ((b << 19) + (row << 8) + col) % (1 << MEM_AW);
  endfunction

  function automatic bit m_any_open();
    return m_open[0] | m_open[1] | m_open[2] | m_open[3];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_err = 0; m_cl = 2; m_ref = 0; m_last_rd = -100;
    for (int i = 0; i < 4; i++) begin m_open[i] = 0; m_row[i] = 0; m_act[i] = -100; end
  endtask

  task automatic model(input sdram_cmd_e c, input int b, input logic [10:0] ad,
                       input logic [3:0] m, input logic [31:0] d, input int t);
    int col, addr;
    logic [31:0] w;
    rd_exp_t e;
    col = int'(ad[7:0]);
    case (c)
      CMD_LOAD_MODE:
        if (m_any_open()) m_err = 1;
        else begin
          m_mode = 1;
          if (ad[2:0] != 3'd0) m_err = 1;
          if (ad[6:4] == 3'd2 || ad[6:4] == 3'd3) m_cl = int'(ad[6:4]);
          else m_err = 1;
        end
      CMD_ACTIVE: begin
        if (m_open[b]) m_err = 1;
        m_open[b] = 1; m_row[b] = int'(ad); m_act[b] = t;
      end
      CMD_READ, CMD_WRITE:
        if (!m_mode || !m_open[b]) m_err = 1;
        else begin
          addr = fold(b, m_row[b], col);
`ifdef SDRAM_RESP_CHECK_EN
          if (t - m_act[b] < T_RCD) m_err = 1;
`endif
          if (c == CMD_READ) begin
            w = m_mem.exists(addr) ? m_mem[addr] : 'x;
            for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = 8'h00;
            e.exp_edge = t + m_cl - 1; e.data = w;
            exp_q.push_back(e);
            m_last_rd = t;
          end else begin
            if (t - m_last_rd >= 1 && t - m_last_rd <= m_cl) m_err = 1;
            w = m_mem.exists(addr) ? m_mem[addr] : 'x;
            for (int i = 0; i < 4; i++) if (!m[i]) w[8*i +: 8] = d[8*i +: 8];
            m_mem[addr] = w;
          end
          if (ad[10]) m_open[b] = 0;
        end
      CMD_PRECHARGE:
        if (ad[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
        else m_open[b] = 0;
      CMD_REFRESH:
        if (m_any_open()) m_err = 1;
        else if (m_ref < 65535) m_ref++;
      CMD_BURST_TERM: m_err = 1;
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input sdram_cmd_e c, input int b, input logic [10:0] ad,
                       input logic [3:0] m, input logic [31:0] d);
    @(negedge clk);
    ncs = 1'b0; {nras, ncas, nwe} = c; ba = 2'(b); a = ad; dqm = m; dq_i = d;
    model(c, b, ad, m, d, cyc + 1);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ncs = 1'b1; {nras, ncas, nwe} = 3'b111;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ncs = 1'b1; {nras, ncas, nwe} = 3'b111;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk(input string tag);
    check({tag, "_cmd_err"}, 32'(cmd_err), 32'(m_err));
    check({tag, "_refresh_cnt"}, 32'(refresh_cnt), 32'(m_ref));
  endtask

  // Monitor: every driven read beat is popped and compared for edge and data
  initial begin : monitor
    rd_exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].exp_edge < cyc) begin
        e = exp_q.pop_front();
        total++; bad++;
        $display("FAIL rd_missing: no data by edge %0d, want %h at edge %0d", cyc, e.data, e.exp_edge);
      end
      if (dq_oe === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: dq_oe high with %h at edge %0d, want none", dq_o, cyc);
        end else begin
          e = exp_q.pop_front();
          check("rd_edge", 32'(cyc), 32'(e.exp_edge));
          check("rd_data", dq_o, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int keys[$];
    int b, col, k, cl;
    logic [3:0] m;
    reset = 1'b1; cke = 1'b1; ncs = 1'b1; {nras, ncas, nwe} = 3'b111;
    ba = '0; a = '0; dqm = '0; dq_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_dq_oe", 32'(dq_oe), 32'd0);
    check("rst_dq_o", dq_o, 32'd0);
    chk("rst");

    // A=0x022 has BL field 2 -> error, CL=2 still loaded
    issue(CMD_LOAD_MODE, 0, 11'h022, 4'h0, 32'h0);
    issue(CMD_ACTIVE, 0, 11'd5, 4'h0, 32'h0);
    nop(T_RCD);
    issue(CMD_WRITE, 0, 11'd3, 4'h0, 32'hA5A55A5A);
    nop(1);
    issue(CMD_READ, 0, 11'd3, 4'h0, 32'h0);
    nop(4);
    chk("mode_bl");

    // Clean mode, RAM retained across reset, byte masks, back-to-back reads
    do_reset();
    issue(CMD_LOAD_MODE, 0, 11'h020, 4'h0, 32'h0);
    issue(CMD_ACTIVE, 0, 11'd5, 4'h0, 32'h0);
    nop(T_RCD);
    issue(CMD_READ, 0, 11'd3, 4'h0, 32'h0);
    nop(3);
    issue(CMD_WRITE, 0, 11'd4, 4'h0, 32'h11223344);
    issue(CMD_WRITE, 0, 11'd4, 4'b1100, 32'hFFFFFFFF);
    issue(CMD_READ, 0, 11'd4, 4'h0, 32'h0);
    issue(CMD_READ, 0, 11'd4, 4'b0101, 32'h0);
    issue(CMD_READ, 0, 11'd3, 4'h0, 32'h0);
    nop(4);
    chk("cl2");

    // Reset while a read is in flight: nothing may be driven
    issue(CMD_READ, 0, 11'd4, 4'h0, 32'h0);
    do_reset();
    nop(3);
    check("midrst_dq_oe", 32'(dq_oe), 32'd0);

    // CL=3 timing
    issue(CMD_LOAD_MODE, 0, 11'h030, 4'h0, 32'h0);
    issue(CMD_ACTIVE, 1, 11'd7, 4'h0, 32'h0);
    nop(T_RCD);
    issue(CMD_WRITE, 1, 11'd9, 4'h0, 32'hCAFEBABE);
    nop(1);
    issue(CMD_READ, 1, 11'd9, 4'b1000, 32'h0);
    issue(CMD_READ, 1, 11'd9, 4'h0, 32'h0);
    nop(5);
    chk("cl3");

    // CL field 5 rejected, CL stays 3
    issue(CMD_PRECHARGE, 0, 11'h400, 4'h0, 32'h0);
    issue(CMD_LOAD_MODE, 0, 11'h050, 4'h0, 32'h0);
    nop(1);
    chk("cl5");
    issue(CMD_ACTIVE, 1, 11'd7, 4'h0, 32'h0);
    nop(T_RCD);
    issue(CMD_READ, 1, 11'd9, 4'h0, 32'h0);
    nop(5);

    // Auto-precharge then READ without ACTIVE
    do_reset();
    issue(CMD_LOAD_MODE, 0, 11'h020, 4'h0, 32'h0);
    issue(CMD_ACTIVE, 0, 11'd5, 4'h0, 32'h0);
    nop(T_RCD);
    issue(CMD_READ, 0, 11'h403, 4'h0, 32'h0);
    nop(1);
    issue(CMD_READ, 0, 11'd3, 4'h0, 32'h0);
    nop(4);
    chk("autopre");
    check("autopre_dq_oe", 32'(dq_oe), 32'd0);

    // Refresh counting and refresh with a bank open
    do_reset();
    repeat (3) issue(CMD_REFRESH, 0, 11'd0, 4'h0, 32'h0);
    nop(1);
    chk("ref3");
    issue(CMD_ACTIVE, 2, 11'd1, 4'h0, 32'h0);
    issue(CMD_REFRESH, 0, 11'd0, 4'h0, 32'h0);
    nop(1);
    chk("ref_open");

`ifdef SDRAM_RESP_CHECK_EN
    do_reset();
    issue(CMD_LOAD_MODE, 0, 11'h020, 4'h0, 32'h0);
    issue(CMD_ACTIVE, 0, 11'd5, 4'h0, 32'h0);
    issue(CMD_READ, 0, 11'd3, 4'h0, 32'h0);
    nop(4);
    chk("trcd");
    check("trcd_err_code", 32'(err_code), 32'(ERR_TRCD));
    do_reset();
    check("trcd_rst_err_code", 32'(err_code), 32'd0);
    check("trcd_rst_cmd_err", 32'(cmd_err), 32'd0);
`endif

    // Randomized traffic over all four banks
    do_reset();
    cl = int'($urandom_range(2, 3));
    issue(CMD_LOAD_MODE, 0, 11'(cl << 4), 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) issue(CMD_ACTIVE, i, 11'($urandom_range(0, 2047)), 4'h0, 32'h0);
    nop(T_RCD);
    for (int n = 0; n < 250; n++) begin
      if (keys.size() == 0 || $urandom_range(0, 1) == 0) begin
        b = int'($urandom_range(0, 3));
        col = int'($urandom_range(0, 15));
        m = m_mem.exists(fold(b, m_row[b], col)) ? 4'($urandom_range(0, 15)) : 4'h0;
        issue(CMD_WRITE, b, 11'(col), m, $urandom);
        keys.push_back(b * 256 + col);
      end else begin
        k = keys[$urandom_range(0, keys.size() - 1)];
        issue(CMD_READ, k / 256, 11'(k % 256), 4'($urandom_range(0, 15)), 32'h0);
      end
      nop(int'($urandom_range(0, 2)));
    end
    nop(6);
    chk("random");
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
